exe_mem_stage_reg: RTL and testbench

EX/MEM pipeline register of the five-stage MIPS core. It captures the execute-stage result, the store data and the writeback controls at each clock edge. It presents them to the memory stage and to the EXE forwarding unit as the `*_EM` signals: `WA_EM`, `WE_EM` and `WS_EM` feed forwarding-source selection directly. It also implements stall and flush for the hazard unit, and keeps a saturating bubble/stall counter for performance debug.

---
 rtl/exe_mem_stage_reg.sv | 141 ++++++++++++++
 tb/tb_exe_mem_stage_reg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/exe_mem_stage_reg.sv
// ============================================================================
// exe_mem_stage_reg
// EX/MEM pipeline register with stall/flush and a saturating bubble counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exe_mem_stage_reg #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Stall,
  input  logic          Flush,
  input  logic          Valid_E,
  input  logic [DW-1:0] ALU_Out_E,
  input  logic [DW-1:0] WD_E,
  input  logic [DW-1:0] PC8_E,
  input  logic [DW-1:0] HI_E,
  input  logic [DW-1:0] LO_E,
  input  logic [4:0]    WA_E,
  input  logic          WE_E,
  input  logic [2:0]    WS_E,
  input  logic          DM_WE_E,
  output logic [DW-1:0] ALU_Out_EM,
  output logic [DW-1:0] WD_EM,
  output logic [DW-1:0] PC8_EM,
  output logic [DW-1:0] HI_EM,
  output logic [DW-1:0] LO_EM,
  output logic [4:0]    WA_EM,
  output logic          WE_EM,
  output logic [2:0]    WS_EM,
  output logic          DM_WE_EM,
  output logic          Valid_EM,
  output logic          Load_EM,
  output logic [CW-1:0] Bubble_Cnt
);

  localparam logic [CW-1:0] C_CNT_MAX = '1;
  localparam logic [2:0]    C_WS_LOAD = 3'd4;

  logic [DW-1:0] alu_q, alu_d, wd_q, wd_d, pc8_q, pc8_d, hi_q, hi_d, lo_q, lo_d;
  logic [4:0]    wa_q, wa_d;
  logic [2:0]    ws_q, ws_d;
  logic          we_q, we_d, dmwe_q, dmwe_d, valid_q, valid_d, load_q, load_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    alu_d   = alu_q;
    wd_d    = wd_q;
    pc8_d   = pc8_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    wa_d    = wa_q;
    ws_d    = ws_q;
    we_d    = we_q;
    dmwe_d  = dmwe_q;
    valid_d = valid_q;
    load_d  = load_q;
    cnt_d   = cnt_q;

    if (Flush) begin
      // Fully zeroed bubble so the forwarding unit can never match on it
      alu_d   = '0;
      wd_d    = '0;
      pc8_d   = '0;
      hi_d    = '0;
      lo_d    = '0;
      wa_d    = '0;
      ws_d    = '0;
      we_d    = 1'b0;
      dmwe_d  = 1'b0;
      valid_d = 1'b0;
      load_d  = 1'b0;
    end else if (!Stall) begin
      alu_d   = ALU_Out_E;
      wd_d    = WD_E;
      pc8_d   = PC8_E;
      hi_d    = HI_E;
      lo_d    = LO_E;
      wa_d    = WA_E;
      ws_d    = WS_E;
      // Illegal selects (5-7) capture raw but never enable a write
      we_d    = WE_E & Valid_E & (WA_E != 5'd0) & (WS_E <= C_WS_LOAD);
      dmwe_d  = DM_WE_E & Valid_E;
      valid_d = Valid_E;
      load_d  = Valid_E & (WS_E == C_WS_LOAD);
    end

    if ((Flush || Stall) && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q   <= '0;
      wd_q    <= '0;
      pc8_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      wa_q    <= '0;
      ws_q    <= '0;
      we_q    <= 1'b0;
      dmwe_q  <= 1'b0;
      valid_q <= 1'b0;
      load_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      alu_q   <= alu_d;
      wd_q    <= wd_d;
      pc8_q   <= pc8_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wa_q    <= wa_d;
      ws_q    <= ws_d;
      we_q    <= we_d;
      dmwe_q  <= dmwe_d;
      valid_q <= valid_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ALU_Out_EM = alu_q;
  assign WD_EM      = wd_q;
  assign PC8_EM     = pc8_q;
  assign HI_EM      = hi_q;
  assign LO_EM      = lo_q;
  assign WA_EM      = wa_q;
  assign WS_EM      = ws_q;
  assign WE_EM      = we_q;
  assign DM_WE_EM   = dmwe_q;
  assign Valid_EM   = valid_q;
  assign Load_EM    = load_q;
  assign Bubble_Cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_mem_stage_reg.sv
// ============================================================================
// tb_exe_mem_stage_reg
// Directed self-checking bench for the EX/MEM pipeline register (CW = 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exe_mem_stage_reg;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, Stall, Flush, Valid_E, WE_E, DM_WE_E;
  logic [DW-1:0] ALU_Out_E, WD_E, PC8_E, HI_E, LO_E;
  logic [4:0]    WA_E;
  logic [2:0]    WS_E;
  logic [DW-1:0] ALU_Out_EM, WD_EM, PC8_EM, HI_EM, LO_EM;
  logic [4:0]    WA_EM;
  logic [2:0]    WS_EM;
  logic          WE_EM, DM_WE_EM, Valid_EM, Load_EM;
  logic [CW-1:0] Bubble_Cnt;

  int n_vec = 0;
  int n_err = 0;

  exe_mem_stage_reg #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .Valid_E(Valid_E),
    .ALU_Out_E(ALU_Out_E), .WD_E(WD_E), .PC8_E(PC8_E), .HI_E(HI_E), .LO_E(LO_E),
    .WA_E(WA_E), .WE_E(WE_E), .WS_E(WS_E), .DM_WE_E(DM_WE_E),
    .ALU_Out_EM(ALU_Out_EM), .WD_EM(WD_EM), .PC8_EM(PC8_EM), .HI_EM(HI_EM),
    .LO_EM(LO_EM), .WA_EM(WA_EM), .WE_EM(WE_EM), .WS_EM(WS_EM),
    .DM_WE_EM(DM_WE_EM), .Valid_EM(Valid_EM), .Load_EM(Load_EM),
    .Bubble_Cnt(Bubble_Cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with non-zero inputs present
    rst = 1'b1; Stall = 1'b1; Flush = 1'b0; Valid_E = 1'b1; WE_E = 1'b1; DM_WE_E = 1'b1;
    ALU_Out_E = 32'hDEAD_BEEF; WD_E = 32'h1111_2222; PC8_E = 32'h3333_4444;
    HI_E = 32'h5555_6666; LO_E = 32'h7777_8888; WA_E = 5'd7; WS_E = 3'd4;
    step(); step();
    check("rst_alu",   ALU_Out_EM, 32'h0);
    check("rst_wd",    WD_EM,      32'h0);
    check("rst_pc8",   PC8_EM,     32'h0);
    check("rst_hi",    HI_EM,      32'h0);
    check("rst_lo",    LO_EM,      32'h0);
    check("rst_wa",    {27'b0, WA_EM}, 32'h0);
    check("rst_ws",    {29'b0, WS_EM}, 32'h0);
    check("rst_flags", {28'b0, WE_EM, DM_WE_EM, Valid_EM, Load_EM}, 32'h0);
    check("rst_cnt",   {28'b0, Bubble_Cnt}, 32'h0);

    // First capture after release
    rst = 1'b0; Stall = 1'b0; DM_WE_E = 1'b0;
    ALU_Out_E = 32'h1234; WD_E = 32'hAAAA_0001; PC8_E = 32'h0040_0010;
    HI_E = 32'h0000_00F1; LO_E = 32'h0000_00F2; WA_E = 5'd8; WS_E = 3'd0;
    step();
    check("cap_alu", ALU_Out_EM, 32'h1234);
    check("cap_wd",  WD_EM,      32'hAAAA_0001);
    check("cap_pc8", PC8_EM,     32'h0040_0010);
    check("cap_hi",  HI_EM,      32'h0000_00F1);
    check("cap_lo",  LO_EM,      32'h0000_00F2);
    check("cap_wa",  {27'b0, WA_EM}, 32'd8);
    check("cap_flags", {28'b0, WE_EM, DM_WE_EM, Valid_EM, Load_EM}, 32'b1010);

    // Stall hold for 3 edges
    WA_E = 5'd9; PC8_E = 32'h0040_0008;
    step();
    check("pre_stall_wa", {27'b0, WA_EM}, 32'd9);
    Stall = 1'b1; WA_E = 5'd3; PC8_E = 32'h0000_0001;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("stall_wa",  {27'b0, WA_EM}, 32'd9);
      check("stall_pc8", PC8_EM, 32'h0040_0008);
      check("stall_cnt", {28'b0, Bubble_Cnt}, 32'(i));
    end
    Stall = 1'b0;
    step();
    check("unstall_wa", {27'b0, WA_EM}, 32'd3);

    // Flush wins over stall, counts once
    Stall = 1'b1; Flush = 1'b1; WS_E = 3'd4; WA_E = 5'd10;
    step();
    check("flush_flags", {28'b0, WE_EM, DM_WE_EM, Valid_EM, Load_EM}, 32'h0);
    check("flush_wa",  {27'b0, WA_EM}, 32'h0);
    check("flush_ws",  {29'b0, WS_EM}, 32'h0);
    check("flush_alu", ALU_Out_EM, 32'h0);
    check("flush_pc8", PC8_EM, 32'h0);
    check("flush_cnt", {28'b0, Bubble_Cnt}, 32'd4);

    // Write-enable qualification
    Stall = 1'b0; Flush = 1'b0; WS_E = 3'd0; WA_E = 5'd0;
    step();
    check("we_wa0", {31'b0, WE_EM}, 32'd0);
    WA_E = 5'd5; Valid_E = 1'b0;
    step();
    check("we_invalid", {31'b0, WE_EM}, 32'd0);
    check("valid_cap0", {31'b0, Valid_EM}, 32'd0);
    Valid_E = 1'b1; WS_E = 3'd6;
    step();
    check("we_badws", {31'b0, WE_EM}, 32'd0);
    check("ws_raw6",  {29'b0, WS_EM}, 32'd6);
    check("load_ws6", {31'b0, Load_EM}, 32'd0);
    WS_E = 3'd0; DM_WE_E = 1'b1; Valid_E = 1'b0;
    step();
    check("dmwe_invalid", {31'b0, DM_WE_EM}, 32'd0);
    Valid_E = 1'b1;
    step();
    check("dmwe_valid", {31'b0, DM_WE_EM}, 32'd1);
    check("we_ok",      {31'b0, WE_EM}, 32'd1);

    // Load flag set then cleared
    DM_WE_E = 1'b0; WS_E = 3'd4; WA_E = 5'd10;
    step();
    check("load_set",  {31'b0, Load_EM}, 32'd1);
    check("load_we",   {31'b0, WE_EM}, 32'd1);
    WS_E = 3'd0;
    step();
    check("load_clr",  {31'b0, Load_EM}, 32'd0);
    check("cnt_kept",  {28'b0, Bubble_Cnt}, 32'd4);

    // Counter saturation at 15
    rst = 1'b1;
    step();
    check("sat_rst0", {28'b0, Bubble_Cnt}, 32'd0);
    rst = 1'b0; Stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("sat_cnt", {28'b0, Bubble_Cnt}, (i > 15) ? 32'd15 : 32'(i));
    end
    // Reset wins over stall
    rst = 1'b1;
    step();
    check("sat_rst1", {28'b0, Bubble_Cnt}, 32'd0);
    check("rst_over_stall_wa", {27'b0, WA_EM}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
